// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter merging NUM_INPUTS valid/ready producers into one
// registered output channel that carries the winner's data and index.
module handshake_rr_arbiter #(
    parameter int unsigned NUM_INPUTS  = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
    input  logic [NUM_INPUTS-1:0]            ins_valid,
    output logic [NUM_INPUTS-1:0]            ins_ready,
    output logic [DATA_WIDTH-1:0]            outs,
    output logic                             outs_valid,
    input  logic                             outs_ready,
    output logic [INDEX_WIDTH-1:0]           index
);

    localparam logic STATE_EMPTY = 1'b0;
    localparam logic STATE_FULL  = 1'b1;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);

    logic                   state_q, state_d;
    logic [DATA_WIDTH-1:0]  outs_q, outs_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

    logic [DATA_WIDTH-1:0]  ins_arr [NUM_INPUTS];
    logic                   grant_found;
    logic [INDEX_WIDTH-1:0] grant_idx;
    logic                   can_load;
    logic                   load;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
        assign ins_arr[i] = ins[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts at ptr and wraps modulo NUM_INPUTS, so the lane just
    // served gets the lowest priority on the next search.
    always_comb begin
        int unsigned            cand;
        logic [INDEX_WIDTH-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NUM_INPUTS) begin
                cand = cand - NUM_INPUTS;
            end
            cand_idx = INDEX_WIDTH'(cand);
            if (!grant_found && ins_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        can_load  = (state_q == STATE_EMPTY) || outs_ready;
        load      = rst && grant_found && can_load;
        ins_ready = '0;
        if (load) begin
            ins_ready[grant_idx] = 1'b1;
        end

        state_d = state_q;
        outs_d  = outs_q;
        index_d = index_q;
        ptr_d   = ptr_q;
        if (load) begin
            state_d = STATE_FULL;
            outs_d  = ins_arr[grant_idx];
            index_d = grant_idx;
            ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + INDEX_WIDTH'(1);
        end else if ((state_q == STATE_FULL) && outs_ready) begin
            state_d = STATE_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= STATE_EMPTY;
            outs_q  <= '0;
            index_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;
            index_q <= index_d;
            ptr_q   <= ptr_d;
        end
    end

    assign outs_valid = (state_q == STATE_FULL);
    assign outs       = outs_q;
    assign index      = index_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Scoreboard bench for handshake_rr_arbiter: a 4-lane instance checked
// against a round-robin reference model, plus a 3-lane instance for wrap.
module tb_handshake_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [127:0] ins;
    logic [3:0]  ins_valid;
    logic [3:0]  ins_ready;
    logic [31:0] outs;
    logic        outs_valid;
    logic        outs_ready;
    logic [1:0]  index;

    logic [23:0] ins3;
    logic [2:0]  v3;
    logic [2:0]  ready3;
    logic [7:0]  outs3;
    logic        ov3;
    logic        oready3;
    logic [1:0]  idx3;

    handshake_rr_arbiter #(.NUM_INPUTS(4), .DATA_WIDTH(32), .INDEX_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready), .index(index)
    );

    handshake_rr_arbiter #(.NUM_INPUTS(3), .DATA_WIDTH(8), .INDEX_WIDTH(2)) dut3 (
        .clk(clk), .rst(rst), .ins(ins3), .ins_valid(v3), .ins_ready(ready3),
        .outs(outs3), .outs_valid(ov3), .outs_ready(oready3), .index(idx3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  idx;
    } token_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    token_t      exp_q[$];
    int unsigned ptr_m;
    logic        full_m;
    token_t      last_m;
    logic [31:0] lane_data [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < 4; i++) ins[i*32 +: 32] = lane_data[i];
    endtask

    // One clock cycle: drive, predict, compare, then advance the model.
    task automatic cycle(input logic [3:0] v, input logic ordy);
        int     g;
        logic   load;
        logic [3:0] exp_ready;
        token_t tok;
        @(negedge clk);
        ins_valid  = v;
        outs_ready = ordy;
        drive_data();
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (int'(ptr_m) + k) % 4;
            if (g < 0 && v[c]) g = c;
        end
        load      = (g >= 0) && (!full_m || ordy);
        exp_ready = '0;
        if (load) exp_ready[g] = 1'b1;
        check("ins_ready", 32'(ins_ready), 32'(exp_ready));
        check("outs_valid", 32'(outs_valid), 32'(full_m));
        if (full_m) begin
            check("outs", outs, exp_q[0].data);
            check("index", 32'(index), 32'(exp_q[0].idx));
        end else begin
            check("outs_held", outs, last_m.data);
            check("index_held", 32'(index), 32'(last_m.idx));
        end
        if (full_m && ordy) begin
            last_m = exp_q.pop_front();
            full_m = 1'b0;
        end
        if (load) begin
            tok.data = lane_data[g];
            tok.idx  = 2'(g);
            exp_q.push_back(tok);
            full_m = 1'b1;
            ptr_m  = (g + 1) % 4;
        end
        @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst        = 1'b0;
            ins_valid  = 4'b1111;
            outs_ready = 1'b1;
            v3         = 3'b111;
            #1;
            check("rst_ins_ready", 32'(ins_ready), 32'h0);
            check("rst_ready3", 32'(ready3), 32'h0);
            @(posedge clk);
        end
        #1;
        check("rst_outs_valid", 32'(outs_valid), 32'h0);
        check("rst_outs", outs, 32'h0);
        check("rst_index", 32'(index), 32'h0);
        rst       = 1'b1;
        ins_valid = '0;
        v3        = '0;
        exp_q.delete();
        full_m = 1'b0;
        ptr_m  = 0;
        last_m = '0;
    endtask

    initial begin
        int exp_i;
        rst = 1'b0; ins = '0; ins_valid = '0; outs_ready = 1'b0;
        ins3 = '0; v3 = '0; oready3 = 1'b1;
        for (int i = 0; i < 4; i++) lane_data[i] = '0;
        full_m = 1'b0; ptr_m = 0; last_m = '0;

        do_reset(2);

        // Single requester on lane 2, then drain; ptr moves to 3.
        lane_data[2] = 32'h0000000D;
        cycle(4'b0100, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Saturation.
        for (int i = 0; i < 4; i++) lane_data[i] = 32'hA0 + 32'(i);
        for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b1);

        // Backpressure with lanes 1 and 3 waiting, then release and idle drain.
        for (int i = 0; i < 5; i++) cycle(4'b1010, 1'b0);
        cycle(4'b1010, 1'b1);
        cycle(4'b1000, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Mid-operation reset with a lane-1 token buffered.
        lane_data[1] = 32'h1111_0001;
        cycle(4'b0010, 1'b1);
        do_reset(1);
        cycle(4'b1111, 1'b1);
        cycle(4'b0000, 1'b1);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            for (int j = 0; j < 4; j++) lane_data[j] = $urandom;
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Three-lane instance: pointer wrap from lane 2 back to lane 0.
        do_reset(1);
        ins3 = {8'h32, 8'h31, 8'h30};
        @(negedge clk); v3 = 3'b100; #1;
        check("w3_ready_l2", 32'(ready3), 32'h4);
        @(posedge clk); #1;
        check("w3_valid", 32'(ov3), 32'h1);
        check("w3_index_l2", 32'(idx3), 32'h2);
        check("w3_outs_l2", 32'(outs3), 32'h32);
        @(negedge clk); v3 = 3'b011; #1;
        check("w3_ready_l0", 32'(ready3), 32'h1);
        @(posedge clk); #1;
        check("w3_index_l0", 32'(idx3), 32'h0);
        check("w3_outs_l0", 32'(outs3), 32'h30);
        @(negedge clk); v3 = 3'b111; #1;
        check("w3_ready_l1", 32'(ready3), 32'h2);
        @(posedge clk); #1;
        check("w3_index_l1", 32'(idx3), 32'h1);
        for (int i = 0; i < 6; i++) begin
            exp_i = (i + 2) % 3;
            @(posedge clk); #1;
            check("w3_rr_index", 32'(idx3), 32'(exp_i));
            check("w3_rr_outs", 32'(outs3), 32'h30 + 32'(exp_i));
        end
        @(negedge clk); v3 = 3'b000;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
